// File: rtl/acc_core_p_if.sv
// Handshake bundle between acc_core_p and its instruction sequencer / I/O block.
// The master modport is the feeding side and the slave modport is the core.
interface acc_core_p_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8
);
  localparam int AW = $clog2(NREG);
  localparam int IW = 3 + 2 * AW;

  logic [IW-1:0]    instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output instr, instr_valid, in_data, in_valid, out_ready,
    input  instr_ready, in_ready, out_data, out_valid
  );

  modport slave (
    input  instr, instr_valid, in_data, in_valid, out_ready,
    output instr_ready, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/acc_core_p.sv
// Accumulator execution core: NREG x WIDTH register file (index 0 is A), IN/ADD/MOV/OUT/
// SUB/AND/NOP, carry/zero flags, valid/ready handshakes on instruction, input and output.
module acc_core_p #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             rst,
  acc_core_p_if.slave      bus,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             busy
);
  localparam int AW = $clog2(NREG);
  localparam int IW = 3 + 2 * AW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_WAIT_IN = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  localparam logic [2:0] OP_IN  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_OUT = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [2:0]       op, new_op;
  logic [AW-1:0]    dest, src, new_src;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   alu;

  // Fields of the held instruction drive EXEC / WAIT_IN; fields of the incoming one drive accept.
  assign op      = instr_q[IW-1 -: 3];
  assign dest    = instr_q[2*AW-1 -: AW];
  assign src     = instr_q[AW-1:0];
  assign new_op  = bus.instr[IW-1 -: 3];
  assign new_src = bus.instr[AW-1:0];
  assign operand = regs_q[src];

  // NOTE: every variable gets a default before the case so no path through it infers a latch.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    regs_d     = regs_q;
    out_data_d = out_data_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    alu        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          if (new_op == OP_IN) begin
            state_d = S_WAIT_IN;
          end else if (new_op == OP_OUT) begin
            out_data_d = regs_q[new_src];
            state_d    = S_SEND;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        // The extra top bit of alu is carry-out for ADD and borrow for SUB.
        case (op)
          OP_ADD:  alu = {1'b0, regs_q[0]} + {1'b0, operand};
          OP_SUB:  alu = {1'b0, regs_q[0]} - {1'b0, operand};
          OP_AND:  alu = {1'b0, regs_q[0] & operand};
          default: alu = '0;
        endcase
        if (op == OP_ADD || op == OP_SUB || op == OP_AND) begin
          regs_d[0] = alu[WIDTH-1:0];
          carry_d   = alu[WIDTH];
          zero_d    = (alu[WIDTH-1:0] == '0);
        end
        if (op == OP_MOV) begin
          regs_d[dest] = operand;
        end
      end
      S_WAIT_IN: begin
        if (bus.in_valid) begin
          regs_d[dest] = bus.in_data;
          state_d      = S_IDLE;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the register file is inside the async reset because every register must read zero after reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      out_data_q <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      out_data_q <= out_data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      regs_q     <= regs_d;
    end
  end

  // instr_ready is gated by rst so nothing is offered while reset is held.
  assign bus.instr_ready = rst && (state_q == S_IDLE);
  assign bus.in_ready    = (state_q == S_WAIT_IN);
  assign bus.out_valid   = (state_q == S_SEND);
  assign bus.out_data    = out_data_q;
  assign acc             = regs_q[0];
  assign carry           = carry_q;
  assign zero            = zero_q;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_acc_core_p.sv
// Self-checking bench for acc_core_p: directed scenarios plus randomized instruction
// streams checked against an arithmetic reference model of the register file and flags.
module tb_acc_core_p;
  localparam int WIDTH = 8;
  localparam int NREG  = 8;
  localparam int AW    = $clog2(NREG);
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             zero;
  logic             busy;

  acc_core_p_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  acc_core_p #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .acc   (acc),
    .carry (carry),
    .zero  (zero),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: register contents and flags as plain integers.
  int unsigned m_reg [NREG];
  bit          m_c;
  bit          m_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_acc"}, 32'(acc), m_reg[0]);
    check({tag, "_carry"}, 32'(carry), 32'(m_c));
    check({tag, "_zero"}, 32'(zero), 32'(m_z));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and return one cycle after the accepting edge.
  task automatic issue(input int op, input int dest, input int src);
    int n;
    logic [2:0]    op3;
    logic [AW-1:0] d, s;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      tick();
      n++;
    end
    check("instr_ready_before_issue", 32'(bus.instr_ready), 1);
    op3 = op[2:0];
    d   = dest[AW-1:0];
    s   = src[AW-1:0];
    bus.instr       = {op3, d, s};
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    check("busy_after_accept", 32'(busy), 1);
    check("instr_ready_low_after_accept", 32'(bus.instr_ready), 0);
  endtask

  // ADD / MOV / SUB / AND / reserved / NOP, with noise on the unrelated handshakes.
  task automatic alu_op(input int op, input int dest, input int src);
    int unsigned a, b, s;
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = WIDTH'($urandom);
    bus.out_ready = 1'($urandom_range(0, 1));
    issue(op, dest, src);
    check("in_ready_idle_in_exec", 32'(bus.in_ready), 0);
    check("out_valid_low_in_exec", 32'(bus.out_valid), 0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    a = m_reg[0];
    b = m_reg[src];
    case (op)
      1: begin
        s = a + b;
        m_c = (s >= MOD);
        m_reg[0] = s % MOD;
        m_z = (m_reg[0] == 0);
      end
      4: begin
        m_c = (a < b);
        m_reg[0] = (a + MOD - b) % MOD;
        m_z = (m_reg[0] == 0);
      end
      5: begin
        m_c = 1'b0;
        m_reg[0] = a & b;
        m_z = (m_reg[0] == 0);
      end
      2: m_reg[dest] = b;
      default: ;
    endcase
    check_flags($sformatf("op%0d", op));
    check("instr_ready_after_exec", 32'(bus.instr_ready), 1);
    check("busy_after_exec", 32'(busy), 0);
  endtask

  task automatic in_op(input int dest, input int value, input int dly);
    issue(0, dest, $urandom_range(0, NREG - 1));
    for (int i = 0; i < dly; i++) begin
      check("in_ready_waiting", 32'(bus.in_ready), 1);
      check("instr_ready_in_wait", 32'(bus.instr_ready), 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.out_ready = 1'b0;
    check("in_ready_at_data", 32'(bus.in_ready), 1);
    bus.in_data  = value[WIDTH-1:0];
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    m_reg[dest] = value % MOD;
    check("in_ready_after_in", 32'(bus.in_ready), 0);
    check("instr_ready_after_in", 32'(bus.instr_ready), 1);
    check_flags("in");
  endtask

  task automatic out_op(input int src, input int dly);
    issue(3, $urandom_range(0, NREG - 1), src);
    for (int i = 0; i < dly; i++) begin
      check("out_valid_waiting", 32'(bus.out_valid), 1);
      check($sformatf("out_data_r%0d", src), 32'(bus.out_data), m_reg[src]);
      check("instr_ready_in_send", 32'(bus.instr_ready), 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = WIDTH'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    check("out_valid_at_ready", 32'(bus.out_valid), 1);
    check($sformatf("out_data_r%0d_ready", src), 32'(bus.out_data), m_reg[src]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_send", 32'(bus.out_valid), 0);
    check("instr_ready_after_send", 32'(bus.instr_ready), 1);
    check_flags("out");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"}, 32'(acc), 0);
    check({tag, "_carry"}, 32'(carry), 0);
    check({tag, "_zero"}, 32'(zero), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_instr_ready"}, 32'(bus.instr_ready), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, d, s, dly, v;
    rst             = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    model_reset();

    // Power-on reset held three cycles.
    repeat (3) tick();
    check_reset_outputs("por");
    check("por_out_data", 32'(bus.out_data), 0);
    rst = 1'b1;
    #1;
    check("instr_ready_after_release", 32'(bus.instr_ready), 1);

    // IN r1 with in_valid delayed 3 cycles, then MOV r0,r1 and ADD r1.
    in_op(1, 8'h7F, 3);
    alu_op(2, 0, 1);
    alu_op(1, 0, 1);
    check("plan_add_acc", 32'(acc), 32'h0FE);

    // ADD overflow, then AND.
    in_op(0, 8'hFF, 0);
    in_op(2, 8'h01, 1);
    alu_op(1, 0, 2);
    check("plan_ovf_carry", 32'(carry), 1);
    alu_op(5, 0, 2);
    check("plan_and_zero", 32'(zero), 1);

    // SUB with borrow, then SUB 0.
    in_op(0, 8'h05, 0);
    in_op(3, 8'h07, 0);
    alu_op(4, 0, 3);
    check("plan_sub_acc", 32'(acc), 32'h0FE);
    alu_op(4, 0, 0);
    check("plan_sub0_zero", 32'(zero), 1);

    // OUT r1 with out_ready held low for 4 cycles.
    out_op(1, 4);

    // Reset while SEND is active: out_valid must drop at once.
    issue(3, 0, 1);
    check("send_before_reset", 32'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_send");
    repeat (3) tick();
    check_reset_outputs("rst_send_held");
    rst = 1'b1;
    #1;
    check("instr_ready_after_send_reset", 32'(bus.instr_ready), 1);

    // Give the flags non-trivial values, then reset during WAIT_IN with in_valid high.
    in_op(0, 8'h3C, 0);
    alu_op(1, 0, 0);
    in_op(5, 8'h80, 2);
    alu_op(4, 0, 5);
    check("pre_reset_carry", 32'(carry), 1);
    issue(0, 4, 0);
    check("wait_in_ready", 32'(bus.in_ready), 1);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    rst          = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_wait_in");
    repeat (3) tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("instr_ready_after_in_reset", 32'(bus.instr_ready), 1);
    alu_op(6, 3, 2);
    out_op(4, 0);

    // Reserved opcode must preserve non-zero state too.
    in_op(0, 8'h81, 0);
    alu_op(1, 0, 0);
    alu_op(6, 0, 0);
    alu_op(7, 5, 0);

    // Randomized instruction stream, biased toward boundary data values.
    for (int k = 0; k < 150; k++) begin
      op  = $urandom_range(0, 7);
      d   = $urandom_range(0, NREG - 1);
      s   = $urandom_range(0, NREG - 1);
      dly = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = MOD - 1;
        default: v = $urandom_range(0, MOD - 1);
      endcase
      case (op)
        0: in_op(d, v, dly);
        3: out_op(s, dly);
        default: alu_op(op, d, s);
      endcase
    end

    // Read back the whole register file through OUT.
    for (int r = 0; r < NREG; r++) out_op(r, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
